// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared constants and state encodings for the UART program loader
package uart_prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         PROG_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CSUM   = 2'd2,
        COMMIT = 2'd3
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// rtl/uart_prog_loader_rx.sv - 8N1 UART byte receiver with input synchronizer
module uart_rx_8n1
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    logic          sync0, sync1, prev_rx;
    rx_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, sh_d;
    logic          valid_d, ferr_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        bit_d   = bit_idx;
        sh_d    = shreg;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_rx && !sync1) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch
                if (cnt == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = sync1 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_d = '0;
                    sh_d  = {sync1, shreg[7:1]};
                    bit_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync1;
                    ferr_d  = !sync1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0     <= 1'b1;
            sync1     <= 1'b1;
            prev_rx   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync0     <= uart_rx;
            sync1     <= sync0;
            prev_rx   <= sync1;
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_d;
            shreg     <= sh_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
        end
    end

    assign rx_data = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART framed program loader: sync, 16 data bytes, checksum, RAM commit
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int TIMEOUT_CLKS = 2700000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 2);
    localparam logic [3:0] LAST_IDX = 4'(PROG_DEPTH - 1);

    logic       rx_valid, frame_err;
    logic [7:0] rx_data;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .frame_err(frame_err)
    );

    load_state_t   state, state_d;
    logic [3:0]    idx, idx_d;
    logic [7:0]    sum, sum_d;
    logic [TW-1:0] gap, gap_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          cpu_q, cpu_d;
    logic          buf_we;
    logic [7:0]    buffer [PROG_DEPTH];

    always_comb begin
        state_d = state;
        idx_d   = idx;
        sum_d   = sum;
        gap_d   = '0;
        err_d   = err_q;
        done_d  = 1'b0;
        buf_we  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD, CSUM: begin
                gap_d = gap + 1'b1;
                // Sync byte values inside a frame are plain data, never a resync
                if (frame_err || gap == TW'(TIMEOUT_CLKS)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rx_valid) begin
                    gap_d = '0;
                    if (state == LOAD) begin
                        buf_we = 1'b1;
                        sum_d  = sum + rx_data;
                        idx_d  = idx + 1'b1;
                        if (idx == LAST_IDX) state_d = CSUM;
                    end else if (rx_data == sum) begin
                        state_d = COMMIT;
                        idx_d   = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                idx_d = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // CPU is held for exactly the frame; release coincides with done or any abort
        cpu_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= '0;
            sum    <= '0;
            gap    <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            cpu_q  <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            sum    <= sum_d;
            gap    <= gap_d;
            err_q  <= err_d;
            done_q <= done_d;
            cpu_q  <= cpu_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buffer[idx] <= rx_data;
    end

    assign wr_en     = (state == COMMIT);
    assign wr_addr   = wr_en ? idx : 4'd0;
    assign wr_data   = wr_en ? buffer[idx] : 8'd0;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_rst_n = cpu_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - randomized self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int TMO = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rx = 1'b1;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_rst_n, busy, done, err;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst_n(cpu_rst_n),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  exp_ram [16];
    logic [7:0]  dut_ram [16];
    int          done_cnt = 0;
    int          exp_done = 0;
    logic        exp_err = 1'b0;
    logic        rel = 1'b0;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rel <= rst;

    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst) begin
            prev_last = 1'b0;
        end else if (rel) begin
            check("cpu_rst_n_vs_busy", 32'(cpu_rst_n), 32'(!busy));
            check("done_after_last_write", 32'(done), 32'(prev_last));
            if (done) done_cnt++;
            if (wr_en) begin
                dut_ram[wr_addr] = wr_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(wr_addr), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[11:8]));
                    check("wr_data", 32'(wr_data), 32'(e[7:0]));
                end
            end else begin
                check("idle_wr_addr", 32'(wr_addr), 32'd0);
                check("idle_wr_data", 32'(wr_data), 32'd0);
            end
            prev_last = wr_en && (wr_addr == 4'hF);
        end
    end

    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy_timeout"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_state(input string name);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
    endtask

    // The model decides commit/abort from the arithmetic checksum of what it sends
    task automatic send_frame(input string name, input logic [7:0] d[16], input logic [7:0] cs);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 16; i++) s = s + d[i];
        send_byte(8'hA5, 1'b1);
        idle($urandom_range(0, 40));
        for (int i = 0; i < 16; i++) begin
            send_byte(d[i], 1'b1);
            idle($urandom_range(0, 40));
        end
        if (cs == s) begin
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back({4'(i), d[i]});
                exp_ram[i] = d[i];
            end
            exp_done++;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        send_byte(cs, 1'b1);
        wait_idle(name);
        check_idle_state(name);
    endtask

    task automatic partial_load(input int nbytes);
        send_byte(8'hA5, 1'b1);
        idle(5);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b1);
            idle($urandom_range(0, 20));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        uart_rx = 1'b1;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_release_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        exp_err = 1'b0;
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] d[16];
        logic [7:0] junk;
        logic [7:0] s;
        for (int i = 0; i < 16; i++) begin
            exp_ram[i] = 8'd0;
            dut_ram[i] = 8'd0;
        end
        apply_reset();

        for (int i = 0; i < 16; i++) d[i] = 8'(i);
        send_frame("frame_00_0f", d, 8'h78);
        check("frame_00_0f_err_lit", 32'(err), 32'd0);
        check("frame_00_0f_ram5_lit", 32'(dut_ram[5]), 32'h05);
        check("frame_00_0f_ram15_lit", 32'(dut_ram[15]), 32'h0F);
        check("frame_00_0f_done_lit", 32'(done_cnt), 32'd1);

        send_frame("bad_csum_79", d, 8'h79);
        check("bad_csum_err_lit", 32'(err), 32'd1);
        check("bad_csum_done_lit", 32'(done_cnt), 32'd1);

        send_byte(8'h3C, 1'b1);
        idle(10);
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
        d[3] = 8'hA5;
        s = 8'd0;
        for (int i = 0; i < 16; i++) s = s + d[i];
        send_frame("junk_then_frame", d, s);

        partial_load(5);
        idle(TMO + 200);
        exp_err = 1'b1;
        check_idle_state("timeout");
        for (int i = 0; i < 16; i++) d[i] = 8'(8'hF0 ^ i);
        s = 8'd0;
        for (int i = 0; i < 16; i++) s = s + d[i];
        send_frame("after_timeout", d, s);

        partial_load(3);
        send_byte(8'h55, 1'b0);
        idle(20);
        exp_err = 1'b1;
        check_idle_state("framing");
        send_frame("after_framing", d, s);

        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(200);
        check_idle_state("glitch");

        partial_load(7);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        apply_reset();
        check_idle_state("reset_mid_load");
        for (int i = 0; i < 16; i++) d[i] = 8'(8'h33 + 7 * i);
        s = 8'd0;
        for (int i = 0; i < 16; i++) s = s + d[i];
        send_frame("after_reset", d, s);

        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, 1'b1);
                idle(10);
            end
            s = 8'd0;
            for (int i = 0; i < 16; i++) begin
                d[i] = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                s = s + d[i];
            end
            if ($urandom_range(0, 2) == 0) s = s + 8'($urandom_range(1, 255));
            send_frame("random_frame", d, s);
        end

        for (int i = 0; i < 16; i++) check("final_ram", 32'(dut_ram[i]), 32'(exp_ram[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
